// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix input parser: ASCII codes, error codes, limits, states.
// The optional idle-timeout fill state exists only when PARSER_TIMEOUT_EN is defined.
package matrix_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'd48;
    localparam logic [7:0] ASCII_NINE  = 8'd57;
    localparam logic [7:0] ASCII_SPACE = 8'd32;
    localparam logic [7:0] ASCII_CR    = 8'd13;
    localparam logic [7:0] ASCII_LF    = 8'd10;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CHAR = 2'd1;
    localparam logic [1:0] ERR_DIM  = 2'd2;
    localparam logic [1:0] ERR_ELEM = 2'd3;

    localparam int unsigned MAX_DIM_DEF = 32'd5;
    localparam int unsigned MAX_VAL_DEF = 32'd9;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_M    = 3'd1,
        ST_GET_N    = 3'd2,
        ST_GET_ELEM = 3'd3,
        ST_DONE     = 3'd4,
        ST_ERR      = 3'd5
`ifdef PARSER_TIMEOUT_EN
        ,
        ST_FILL     = 3'd6
`endif
    } state_t;

    typedef enum logic [1:0] {
        CLS_DIGIT   = 2'd0,
        CLS_SEP     = 2'd1,
        CLS_ILLEGAL = 2'd2
    } byte_class_t;

    function automatic byte_class_t classify_byte(input logic [7:0] b);
        byte_class_t c;
        if (b >= ASCII_ZERO && b <= ASCII_NINE) begin
            c = CLS_DIGIT;
        end else if (b == ASCII_SPACE || b == ASCII_CR || b == ASCII_LF) begin
            c = CLS_SEP;
        end else begin
            c = CLS_ILLEGAL;
        end
        return c;
    endfunction

endpackage

// File: rtl/token_accumulator.sv
// Classifies incoming bytes and accumulates one decimal token into a saturating 8-bit value.
module token_accumulator
    import matrix_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output byte_class_t byte_class,
    output logic [7:0]  value,
    output logic        ovf,
    output logic        tok_end
);

    logic [7:0]  acc_r;
    logic        ovf_r;
    logic        pend_r;
    logic [11:0] next_acc_s;

    // Byte classification and candidate acc*10+digit (ASCII digits carry their value in the low nibble)
    always_comb begin
        byte_class = classify_byte(rx_data);
        next_acc_s = ({4'd0, acc_r} * 12'd10) + {8'd0, rx_data[3:0]};
        tok_end    = rx_valid && (byte_class == CLS_SEP) && pend_r;
    end

    // Accumulator with sticky saturation; a separator closes and clears the token
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc_r  <= 8'd0;
            ovf_r  <= 1'b0;
            pend_r <= 1'b0;
        end else if (rx_valid && byte_class == CLS_DIGIT) begin
            pend_r <= 1'b1;
            if (ovf_r || next_acc_s > 12'd255) begin
                acc_r <= 8'd255;
                ovf_r <= 1'b1;
            end else begin
                acc_r <= next_acc_s[7:0];
            end
        end else if (rx_valid && byte_class == CLS_SEP) begin
            acc_r  <= 8'd0;
            ovf_r  <= 1'b0;
            pend_r <= 1'b0;
        end else begin
            acc_r  <= acc_r;
            ovf_r  <= ovf_r;
            pend_r <= pend_r;
        end
    end

    assign value = acc_r;
    assign ovf   = ovf_r;

endmodule

// File: rtl/matrix_input_parser.sv
// Parses "m n e0 e1 ..." ASCII into storage writes with a done/error handshake.
// Define PARSER_TIMEOUT_EN to zero-fill the remaining elements after TIMEOUT_CYC idle cycles.
module matrix_input_parser
    import matrix_pkg::*;
#(
    parameter int unsigned MAX_DIM = MAX_DIM_DEF,
    parameter int unsigned MAX_VAL = MAX_VAL_DEF,
    parameter logic [31:0] TIMEOUT_CYC = 32'd500_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic [7:0]  i_base_addr,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_wr_en,
    output logic [7:0]  o_wr_addr,
    output logic [31:0] o_wr_data,
    output logic [31:0] o_m,
    output logic [31:0] o_n,
    output logic        o_done,
    output logic        o_err,
    output logic [1:0]  o_err_code
);

    localparam logic [7:0] MAX_DIM_B = 8'(MAX_DIM);
    localparam logic [7:0] MAX_VAL_B = 8'(MAX_VAL);

    state_t      state_r, nxt_state_s;
    logic [7:0]  index_r, nxt_index_s;
    logic [7:0]  base_r, nxt_base_s;
    logic [7:0]  total_r, nxt_total_s;
    logic [31:0] nxt_m_s, nxt_n_s, nxt_wr_data_s;
    logic [7:0]  nxt_wr_addr_s;
    logic        nxt_wr_en_s, nxt_done_s, nxt_err_s;
    logic [1:0]  nxt_code_s;
    logic        acc_clr_s, elem_req_s;
    byte_class_t byte_class_s;
    logic [7:0]  value_s;
    logic        ovf_s, tok_end_s;

    token_accumulator u_tok (
        .clk        (clk),
        .rst        (rst),
        .clr        (acc_clr_s),
        .rx_data    (i_rx_data),
        .rx_valid   (i_rx_valid),
        .byte_class (byte_class_s),
        .value      (value_s),
        .ovf        (ovf_s),
        .tok_end    (tok_end_s)
    );

`ifdef PARSER_TIMEOUT_EN
    logic [31:0] tmo_cnt_r;
    logic        tmo_hit_s;

    assign tmo_hit_s = (state_r == ST_GET_ELEM) && !i_rx_valid && (tmo_cnt_r == TIMEOUT_CYC);

    // Idle-cycle counter while waiting for elements, restarted by every received byte
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_r <= 32'd0;
        end else if (state_r != ST_GET_ELEM || i_rx_valid || tmo_hit_s) begin
            tmo_cnt_r <= 32'd0;
        end else begin
            tmo_cnt_r <= tmo_cnt_r + 32'd1;
        end
    end
`endif

    // Next-state and next-output logic; dropping i_en aborts any session
    always_comb begin
        nxt_state_s   = state_r;
        nxt_index_s   = index_r;
        nxt_base_s    = base_r;
        nxt_total_s   = total_r;
        nxt_m_s       = o_m;
        nxt_n_s       = o_n;
        nxt_wr_en_s   = 1'b0;
        nxt_wr_addr_s = o_wr_addr;
        nxt_wr_data_s = o_wr_data;
        nxt_done_s    = o_done;
        nxt_err_s     = o_err;
        nxt_code_s    = o_err_code;
        acc_clr_s     = 1'b0;
        elem_req_s    = 1'b0;
        if (!i_en) begin
            nxt_state_s = ST_IDLE;
            nxt_done_s  = 1'b0;
            nxt_err_s   = 1'b0;
            acc_clr_s   = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    acc_clr_s   = 1'b1;
                    nxt_state_s = ST_GET_M;
                    nxt_index_s = 8'd0;
                    nxt_base_s  = i_base_addr;
                    nxt_done_s  = 1'b0;
                    nxt_err_s   = 1'b0;
                    nxt_code_s  = ERR_NONE;
                end
                ST_GET_M, ST_GET_N: begin
                    if (i_rx_valid && byte_class_s == CLS_ILLEGAL) begin
                        nxt_state_s = ST_ERR;
                        nxt_done_s  = 1'b1;
                        nxt_err_s   = 1'b1;
                        nxt_code_s  = ERR_CHAR;
                    end else if (tok_end_s) begin
                        if (ovf_s || value_s == 8'd0 || value_s > MAX_DIM_B) begin
                            nxt_state_s = ST_ERR;
                            nxt_done_s  = 1'b1;
                            nxt_err_s   = 1'b1;
                            nxt_code_s  = ERR_DIM;
                        end else if (state_r == ST_GET_M) begin
                            nxt_m_s     = {24'd0, value_s};
                            nxt_state_s = ST_GET_N;
                        end else begin
                            nxt_n_s     = {24'd0, value_s};
                            nxt_total_s = o_m[7:0] * value_s;
                            nxt_state_s = ST_GET_ELEM;
                        end
                    end else begin
                        nxt_state_s = state_r;
                    end
                end
                ST_GET_ELEM: begin
                    if (i_rx_valid && byte_class_s == CLS_ILLEGAL) begin
                        nxt_state_s = ST_ERR;
                        nxt_done_s  = 1'b1;
                        nxt_err_s   = 1'b1;
                        nxt_code_s  = ERR_CHAR;
                    end else if (tok_end_s) begin
                        elem_req_s = 1'b1;
`ifdef PARSER_TIMEOUT_EN
                    end else if (tmo_hit_s) begin
                        acc_clr_s   = 1'b1;
                        nxt_state_s = ST_FILL;
                        elem_req_s  = (value_s != 8'd0);
`endif
                    end else begin
                        nxt_state_s = state_r;
                    end
                end
`ifdef PARSER_TIMEOUT_EN
                ST_FILL: begin
                    nxt_wr_en_s   = 1'b1;
                    nxt_wr_addr_s = base_r + index_r;
                    nxt_wr_data_s = 32'd0;
                    nxt_index_s   = index_r + 8'd1;
                    if (index_r == total_r - 8'd1) begin
                        nxt_state_s = ST_DONE;
                    end else begin
                        nxt_state_s = ST_FILL;
                    end
                end
`endif
                ST_DONE: begin
                    nxt_done_s = 1'b1;
                    nxt_err_s  = 1'b0;
                end
                ST_ERR: begin
                    nxt_done_s = 1'b1;
                    nxt_err_s  = 1'b1;
                end
                default: begin
                    nxt_state_s = ST_IDLE;
                end
            endcase
        end
        // Element completion shared by the separator path and the timeout path
        if (elem_req_s) begin
            if (ovf_s || value_s > MAX_VAL_B) begin
                nxt_state_s = ST_ERR;
                nxt_done_s  = 1'b1;
                nxt_err_s   = 1'b1;
                nxt_code_s  = ERR_ELEM;
            end else begin
                nxt_wr_en_s   = 1'b1;
                nxt_wr_addr_s = base_r + index_r;
                nxt_wr_data_s = {24'd0, value_s};
                nxt_index_s   = index_r + 8'd1;
                if (index_r == total_r - 8'd1) begin
                    nxt_state_s = ST_DONE;
                end else begin
                    nxt_state_s = nxt_state_s;
                end
            end
        end else begin
            nxt_index_s = nxt_index_s;
        end
    end

    // State, index and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            index_r    <= 8'd0;
            base_r     <= 8'd0;
            total_r    <= 8'd0;
            o_m        <= 32'd0;
            o_n        <= 32'd0;
            o_wr_en    <= 1'b0;
            o_wr_addr  <= 8'd0;
            o_wr_data  <= 32'd0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            o_err_code <= ERR_NONE;
        end else begin
            state_r    <= nxt_state_s;
            index_r    <= nxt_index_s;
            base_r     <= nxt_base_s;
            total_r    <= nxt_total_s;
            o_m        <= nxt_m_s;
            o_n        <= nxt_n_s;
            o_wr_en    <= nxt_wr_en_s;
            o_wr_addr  <= nxt_wr_addr_s;
            o_wr_data  <= nxt_wr_data_s;
            o_done     <= nxt_done_s;
            o_err      <= nxt_err_s;
            o_err_code <= nxt_code_s;
        end
    end

endmodule

// File: tb/tb_matrix_input_parser.sv
// Self-checking bench for matrix_input_parser: directed cases plus random sessions
// checked against a token-level reference model.
module tb_matrix_input_parser;

    logic        clk;
    logic        rst;
    logic        i_en;
    logic [7:0]  i_base_addr;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        o_wr_en;
    logic [7:0]  o_wr_addr;
    logic [31:0] o_wr_data;
    logic [31:0] o_m;
    logic [31:0] o_n;
    logic        o_done;
    logic        o_err;
    logic [1:0]  o_err_code;

    int n_checks = 0;
    int n_fails  = 0;

    logic [7:0]  stim_q[$];
    logic [39:0] wr_q[$];
    logic [39:0] exp_wr_q[$];
    logic [1:0]  exp_code;
    logic        exp_done;
    int          exp_m, exp_n;

    matrix_input_parser #(.TIMEOUT_CYC(32'd100)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_en       (i_en),
        .i_base_addr(i_base_addr),
        .i_rx_data  (i_rx_data),
        .i_rx_valid (i_rx_valid),
        .o_wr_en    (o_wr_en),
        .o_wr_addr  (o_wr_addr),
        .o_wr_data  (o_wr_data),
        .o_m        (o_m),
        .o_n        (o_n),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_err_code (o_err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every write as {addr, data}; values read here are those of the cycle just ended
    always @(posedge clk) begin
        if (o_wr_en === 1'b1) wr_q.push_back({o_wr_addr, o_wr_data});
    end

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_str(input string s);
        for (int i = 0; i < s.len(); i++) stim_q.push_back(s[i]);
    endtask

    task automatic add_num(input int v);
        add_str($sformatf("%0d", v));
    endtask

    task automatic add_sep();
        repeat ($urandom_range(1, 2)) begin
            case ($urandom_range(0, 2))
                0: stim_q.push_back(8'd32);
                1: stim_q.push_back(8'd13);
                default: stim_q.push_back(8'd10);
            endcase
        end
    endtask

    // Reference: split the byte stream into decimal tokens and apply the m, n, elements rules
    task automatic model(input logic [7:0] base);
        int tok, k;
        bit have;
        int dims[2];
        logic [7:0] b;
        exp_wr_q.delete();
        exp_code = 2'd0; exp_done = 1'b0;
        tok = 0; k = 0; have = 0; dims[0] = 0; dims[1] = 0;
        foreach (stim_q[i]) begin
            if (exp_done) break;
            b = stim_q[i];
            if (b >= 8'd48 && b <= 8'd57) begin
                tok  = (tok > 999) ? 1000 : tok * 10 + int'(b) - 48;
                have = 1;
            end else if (b == 8'd32 || b == 8'd13 || b == 8'd10) begin
                if (have) begin
                    if (k < 2) begin
                        if (tok < 1 || tok > 5) begin exp_code = 2'd2; exp_done = 1'b1; end
                        else dims[k] = tok;
                    end else if (tok > 9) begin
                        exp_code = 2'd3; exp_done = 1'b1;
                    end else begin
                        exp_wr_q.push_back({base + 8'(k - 2), 32'(tok)});
                        if (k - 2 == dims[0] * dims[1] - 1) exp_done = 1'b1;
                    end
                    k++; tok = 0; have = 0;
                end
            end else begin
                exp_code = 2'd1; exp_done = 1'b1;
            end
        end
        exp_m = dims[0]; exp_n = dims[1];
    endtask

    task automatic start_session(input logic [7:0] base);
        @(negedge clk);
        i_en = 1'b1; i_base_addr = base;
        @(negedge clk);
        wr_q.delete();
    endtask

    task automatic send_stim(input int max_gap);
        foreach (stim_q[i]) begin
            i_rx_data = stim_q[i]; i_rx_valid = 1'b1;
            @(negedge clk);
            i_rx_valid = 1'b0;
            if (i != stim_q.size() - 1) repeat ($urandom_range(0, max_gap)) @(negedge clk);
        end
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (o_done !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
    endtask

    task automatic end_session(input string tag);
        i_en = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, ".done_clr"}, o_done, 1'b0);
    endtask

    // One complete session: model, drive, wait for done and compare everything observable
    task automatic run_session(input string tag, input logic [7:0] base, input int max_gap, input int exp_lat);
        int cyc;
        model(base);
        start_session(base);
        send_stim(max_gap);
        wait_done(200, cyc);
        check({tag, ".done"}, o_done, exp_done);
        check({tag, ".err"}, o_err, (exp_code != 2'd0));
        check({tag, ".code"}, o_err_code, exp_code);
        if (exp_lat >= 0) check({tag, ".latency"}, cyc, exp_lat);
        check({tag, ".nwr"}, wr_q.size(), exp_wr_q.size());
        for (int i = 0; i < wr_q.size() && i < exp_wr_q.size(); i++)
            check($sformatf("%s.wr%0d", tag, i), wr_q[i], exp_wr_q[i]);
        if (exp_code == 2'd0) begin
            check({tag, ".m"}, o_m, exp_m);
            check({tag, ".n"}, o_n, exp_n);
        end
        end_session(tag);
    endtask

    initial begin
        int m, n, cnt, mode, v;
        logic [7:0] bad_chars[4];
        bad_chars[0] = 8'h41; bad_chars[1] = 8'h2C; bad_chars[2] = 8'h09; bad_chars[3] = 8'h2D;
        rst = 1'b1; i_en = 1'b0; i_base_addr = 8'd0; i_rx_data = 8'd0; i_rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.wr_en", o_wr_en, 1'b0);
        check("rst.wr_addr", o_wr_addr, 8'd0);
        check("rst.wr_data", o_wr_data, 32'd0);
        check("rst.m", o_m, 32'd0);
        check("rst.n", o_n, 32'd0);
        check("rst.done", o_done, 1'b0);
        check("rst.err", o_err, 1'b0);
        check("rst.code", o_err_code, 2'd0);
        rst = 1'b0;

        stim_q.delete(); add_str("2 3 1 2 3 4 5 6 ");
        run_session("basic", 8'h10, 0, 1);
        stim_q.delete(); add_str("6 1 ");
        run_session("dim_hi", 8'h00, 0, -1);
        stim_q.delete(); add_str("1 1 12 ");
        run_session("elem_hi", 8'h30, 0, 0);
        stim_q.delete(); add_str("2 2 1x");
        run_session("illegal", 8'h50, 0, 0);
        stim_q.delete(); add_str("2 2 1 1 1 1 ");
        run_session("wrap", 8'hFE, 0, 1);
        stim_q.delete(); add_str("\r\n1 5  0\n9 300 ");
        run_session("ovf_elem", 8'h08, 0, 0);

        // Reset in the middle of a back-to-back stream
        stim_q.delete(); add_str("3 3 1 2 ");
        start_session(8'h60);
        send_stim(0);
        rst = 1'b1; i_en = 1'b0; i_rx_data = 8'd51; i_rx_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst.wr_en", o_wr_en, 1'b0);
        check("midrst.m", o_m, 32'd0);
        check("midrst.n", o_n, 32'd0);
        check("midrst.done", o_done, 1'b0);
        check("midrst.wr_data", o_wr_data, 32'd0);
        wr_q.delete();
        stim_q.delete(); add_str(" 4 5 ");
        send_stim(0);
        repeat (3) @(negedge clk);
        check("midrst.nwr", wr_q.size(), 0);
        stim_q.delete(); add_str("2 2 5 6 7 8 ");
        run_session("after_rst", 8'h70, 0, 1);

        // Enable dropped right after the first element
        stim_q.delete(); add_str("3 3 4 ");
        start_session(8'h40);
        send_stim(0);
        i_en = 1'b0;
        stim_q.delete(); add_str("5 6 ");
        send_stim(0);
        repeat (3) @(negedge clk);
        check("abort.nwr", wr_q.size(), 1);
        if (wr_q.size() > 0) check("abort.wr0", wr_q[0], {8'h40, 32'd4});
        check("abort.done", o_done, 1'b0);

`ifdef PARSER_TIMEOUT_EN
        begin
            int cyc;
            stim_q.delete(); add_str("2 2 7 ");
            start_session(8'h20);
            send_stim(0);
            wait_done(400, cyc);
            check("tmo.done", o_done, 1'b1);
            check("tmo.err", o_err, 1'b0);
            check("tmo.nwr", wr_q.size(), 4);
            for (int i = 0; i < wr_q.size() && i < 4; i++)
                check($sformatf("tmo.wr%0d", i), wr_q[i], {8'h20 + 8'(i), (i == 0) ? 32'd7 : 32'd0});
            end_session("tmo");
        end
`endif

        // Random sessions: legal matrices plus injected dimension, element and character errors
        for (int s = 0; s < 12; s++) begin
            stim_q.delete();
            mode = $urandom_range(0, 4);
            m = $urandom_range(1, 5);
            n = $urandom_range(1, 5);
            if (mode == 1) m = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(6, 300);
            if ($urandom_range(0, 1) == 1) add_sep();
            add_num(m); add_sep(); add_num(n); add_sep();
            cnt = (m >= 1 && m <= 5) ? m * n : 2;
            for (int e = 0; e < cnt; e++) begin
                v = $urandom_range(0, 9);
                if (mode == 2 && e == cnt / 2) v = $urandom_range(10, 400);
                if (mode == 3 && e == cnt - 1) stim_q.push_back(bad_chars[$urandom_range(0, 3)]);
                add_num(v); add_sep();
            end
            if ($urandom_range(0, 1) == 1) add_str("8 ");
            run_session($sformatf("rand%0d", s), 8'($urandom_range(0, 255)), 2, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
